data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL take parameter DEPTH, default 1024: number of 32-bit words stored.
REQ-002 SHALL take parameter LATENCY, default 2: wait cycles before a response, legal range 1..15.
REQ-003 SHALL take parameter DEBUG, default 0: when nonzero, print a $display line on every committed write.
REQ-004 clk  input  1  single clock; all state updates on the posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  1  request valid; held stable with its fields until ack.
REQ-007 read  input  1  request is a word load.
REQ-008 write  input  1  request is a word store.
REQ-009 address  input  32  byte address; word index is address[31:2].
REQ-010 wdata  input  32  store data.
REQ-011 rdata  output  32  load data, registered.
REQ-012 ack  output  1  one-cycle response strobe, registered.
REQ-013 err  output  1  response carries an error; meaningful only while ack=1.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 IDLE: on an edge with req=1, SHALL latch address, wdata, read and write, load cnt=LATENCY-1, and go to WAIT; with req=0 it SHALL stay in IDLE.
REQ-017 WAIT: if cnt!=0, SHALL decrement cnt; if cnt==0, SHALL perform the access, drive ack<=1, and go to RESP.
REQ-018 RESP: SHALL drive ack<=0 and go to IDLE unconditionally; no request is accepted on this edge.
REQ-019 Timing: a request accepted at edge E0 SHALL see ack high during the cycle after edge E0+LATENCY.
REQ-020 Throughput: at most one request per LATENCY+2 cycles.
REQ-021 A req still high in IDLE after RESP SHALL be treated as a new request.
REQ-022 Inputs SHALL be ignored in WAIT and RESP; only latched copies are used.
REQ-023 Error conditions, checked at the access edge:
  - address[1:0]!=0 (unaligned), or
  - address[31:2]>=DEPTH (out of range), or
  - read==write (both set or both clear).
REQ-024 On error: err<=1, rdata<=32'h0, and no array write.
REQ-025 Legal load: rdata<=arr[address[31:2]], err<=0.
REQ-026 Legal store: arr[address[31:2]]<=wdata at the access edge, err<=0, rdata unchanged.
REQ-027 A load issued after a store to the same word SHALL return the stored value.
REQ-028 rdata SHALL hold its value between responses.
REQ-029 err SHALL be 0 whenever ack is 0.
REQ-030 Array contents SHALL NOT be reset and are unspecified until written.

Reset
REQ-031 reset=1 at an edge SHALL force state=IDLE, cnt=0, ack=0, err=0, rdata=32'h0; busy SHALL then read 0.
REQ-032 Reset SHALL override any concurrent req.
REQ-033 Reset during WAIT SHALL abort the pending access: no array write and no ack.
REQ-034 The array SHALL be unaffected by reset.

Verification
REQ-035 Store, then load, LATENCY=2: store 32'hDEADBEEF at 0x10, then load 0x10 -> each ack 3 cycles after acceptance, rdata=32'hDEADBEEF, err=0.
REQ-036 Errors: load at 0x13 -> ack, err=1, rdata=0; load at DEPTH*4 -> ack, err=1; store with read=write=1 -> err=1, and a later load of that word returns the prior value.
REQ-037 Back-to-back: hold req=1 for 3 loads at 0x0, 0x4, 0x8 with the address changed after each ack -> acks exactly 4 cycles apart, correct data each time.
REQ-038 Reset in WAIT: store 32'h1234 at 0x20 with an old value of 32'h5; assert reset one cycle after acceptance -> no ack, busy=0, and a later load of 0x20 returns 32'h5.
REQ-039 LATENCY=1 build: single load -> ack in the cycle after edge E0+1; busy high exactly 2 cycles.

Source files
------------

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a fixed-latency request/response handshake.
// A request is latched in IDLE, waits LATENCY cycles, then answers with a one-cycle ack.
module data_mem_resp #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int DEBUG   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_we;

  logic [31:0] arr [DEPTH];

  logic [AW-1:0] idx;
  logic          access_err;

  assign idx        = addr_q[AW+1:2];
  // Only the latched request is judged, so inputs may change freely after acceptance.
  assign access_err = (addr_q[1:0] != 2'b00) ||
                      ({2'b00, addr_q[31:2]} >= 32'(DEPTH)) ||
                      (read_q == write_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = address;
          wdata_d = wdata;
          read_d  = read;
          write_d = write;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = RESP;
          if (access_err) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (read_q) begin
            rdata_d = arr[idx];
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is never cleared; reset only blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) arr[idx] <= wdata_q;
  end

  generate
    if (DEBUG != 0) begin : g_dbg
      always @(posedge clk) begin
        if (mem_we && !reset)
          $display("data_mem_resp: write [%08h] <= %08h", addr_q, wdata_q);
      end
    end
  endgenerate

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench: LATENCY=2 instance for function/errors/reset, LATENCY=1 instance for timing.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, read, write;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ack, err, busy;

  logic        req1, read1, write1;
  logic [31:0] address1, wdata1;
  logic [31:0] rdata1;
  logic        ack1, err1, busy1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH(1024), .LATENCY(2), .DEBUG(0)) dut (
    .clk(clk), .reset(reset), .req(req), .read(read), .write(write),
    .address(address), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  data_mem_resp #(.DEPTH(1024), .LATENCY(1), .DEBUG(0)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .read(read1), .write(write1),
    .address(address1), .wdata(wdata1), .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=2 instance; returns ticks from drive to ack (20 = timeout).
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int lat);
    req = 1'b1; read = rd; write = wr; address = a; wdata = wd;
    lat = 20;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ack === 1'b1) begin
        lat = c;
        break;
      end
    end
    req = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    tick();
    chk({tag, "_ack_low"}, 32'(ack), 32'd0);
    chk({tag, "_err_low"}, 32'(err), 32'd0);
  endtask

  int lat;
  int t [3];
  logic [31:0] d [3];

  initial begin
    reset = 1'b1; req = 1'b0; read = 1'b0; write = 1'b0; address = '0; wdata = '0;
    req1 = 1'b0; read1 = 1'b0; write1 = 1'b0; address1 = '0; wdata1 = '0;
    tick(); tick();
    chk("rst_ack",   32'(ack),  32'd0);
    chk("rst_err",   32'(err),  32'd0);
    chk("rst_rdata", rdata,     32'h0);
    chk("rst_busy",  32'(busy), 32'd0);

    // reset wins over a concurrent request
    req = 1'b1; read = 1'b1; address = 32'h0;
    tick();
    chk("rst_vs_req_busy", 32'(busy), 32'd0);
    req = 1'b0; read = 1'b0;
    reset = 1'b0;
    tick();

    // store then load
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat);
    chk("st_lat", 32'(lat), 32'd3);
    chk("st_err", 32'(err), 32'd0);
    finish_resp("st");
    chk("st_idle_busy", 32'(busy), 32'd0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, lat);
    chk("ld_lat",   32'(lat), 32'd3);
    chk("ld_rdata", rdata,    32'hDEADBEEF);
    chk("ld_err",   32'(err), 32'd0);
    finish_resp("ld");
    chk("ld_hold", rdata, 32'hDEADBEEF);

    // error cases
    do_req(1'b1, 1'b0, 32'h13, 32'h0, lat);
    chk("unal_err",   32'(err), 32'd1);
    chk("unal_rdata", rdata,    32'h0);
    finish_resp("unal");
    do_req(1'b1, 1'b0, 32'h1000, 32'h0, lat);
    chk("oor_lat", 32'(lat), 32'd3);
    chk("oor_err", 32'(err), 32'd1);
    finish_resp("oor");
    do_req(1'b1, 1'b1, 32'h10, 32'h11111111, lat);
    chk("rw_both_err", 32'(err), 32'd1);
    finish_resp("rw_both");
    do_req(1'b0, 1'b0, 32'h10, 32'h22222222, lat);
    chk("rw_none_err", 32'(err), 32'd1);
    finish_resp("rw_none");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, lat);
    chk("after_err_rdata", rdata, 32'hDEADBEEF);
    finish_resp("after_err");

    // back-to-back loads with req held high
    do_req(1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, lat); tick();
    do_req(1'b0, 1'b1, 32'h4, 32'hB1B1B1B1, lat); tick();
    do_req(1'b0, 1'b1, 32'h8, 32'hC2C2C2C2, lat); tick();
    begin
      int k;
      k = 0;
      req = 1'b1; read = 1'b1; write = 1'b0; address = 32'h0;
      for (int c = 1; c <= 30 && k < 3; c++) begin
        tick();
        if (ack === 1'b1) begin
          t[k] = c; d[k] = rdata; k++;
          address = 32'(k * 4);
        end
      end
      req = 1'b0; read = 1'b0;
      chk("b2b_count", 32'(k), 32'd3);
    end
    chk("b2b_t0",  32'(t[0]),        32'd3);
    chk("b2b_gap1", 32'(t[1] - t[0]), 32'd4);
    chk("b2b_gap2", 32'(t[2] - t[1]), 32'd4);
    chk("b2b_d0", d[0], 32'hA0A0A0A0);
    chk("b2b_d1", d[1], 32'hB1B1B1B1);
    chk("b2b_d2", d[2], 32'hC2C2C2C2);
    finish_resp("b2b");

    // reset during WAIT aborts the store
    do_req(1'b0, 1'b1, 32'h20, 32'h5, lat); tick();
    req = 1'b1; write = 1'b1; read = 1'b0; address = 32'h20; wdata = 32'h1234;
    tick();
    chk("rw_accept_busy", 32'(busy), 32'd1);
    req = 1'b0; write = 1'b0; reset = 1'b1;
    tick();
    chk("rw_busy",  32'(busy), 32'd0);
    chk("rw_ack",   32'(ack),  32'd0);
    chk("rw_rdata", rdata,     32'h0);
    reset = 1'b0;
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack !== 1'b0) lat++;
    end
    chk("rw_no_ack", 32'(lat), 32'd0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, lat);
    chk("rw_old_value", rdata, 32'h5);
    finish_resp("rw_load");

    // LATENCY=1 instance
    req1 = 1'b1; write1 = 1'b1; address1 = 32'h4; wdata1 = 32'hCAFEF00D;
    tick();
    chk("l1_st_busy0", 32'(busy1), 32'd1);
    chk("l1_st_ack0",  32'(ack1),  32'd0);
    tick();
    chk("l1_st_ack1", 32'(ack1), 32'd1);
    chk("l1_st_err",  32'(err1), 32'd0);
    req1 = 1'b0; write1 = 1'b0;
    tick();
    chk("l1_st_idle", 32'(busy1), 32'd0);
    req1 = 1'b1; read1 = 1'b1;
    tick();
    chk("l1_ld_busy0", 32'(busy1), 32'd1);
    chk("l1_ld_ack0",  32'(ack1),  32'd0);
    tick();
    chk("l1_ld_ack1",  32'(ack1),  32'd1);
    chk("l1_ld_busy1", 32'(busy1), 32'd1);
    chk("l1_ld_rdata", rdata1,     32'hCAFEF00D);
    chk("l1_ld_err",   32'(err1),  32'd0);
    req1 = 1'b0; read1 = 1'b0;
    tick();
    chk("l1_ld_idle", 32'(busy1), 32'd0);
    chk("l1_ld_ackl", 32'(ack1),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
